// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//   Round-robin arbiter/sequencer sharing one byte-wide UART transmitter among
//   N requesters. A grant is held for a whole packet (terminated by the byte
//   flagged req_last). Bytes are launched with a one-cycle tx_din_vld pulse and
//   pacing follows the transmitter's tx_rdy level.
//
// Parameters
//   N       : number of requesters (2..8)
//   TIMEOUT : idle cycles a grant holder may leave req_vld low mid-packet
//             before the grant is revoked (0 disables, else 1..65535)
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   req_vld     : [N]   requester i offers a byte
//   req_data    : [N*8] byte of requester i at [8i+7:8i]
//   req_last    : [N]   offered byte ends the packet
//   req_ack     : [N]   one-cycle pulse, byte of requester i was taken
//   tx_din      : [8]   byte to transmitter (registered, held outside SEND)
//   tx_din_vld  : start pulse to transmitter (registered)
//   tx_rdy      : transmitter idle level
//   gnt_id      : index of current or last grant holder
//   busy        : state machine is not idle
//   err_timeout : one-cycle pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_vld,
  input  logic [N*8-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ack,
  output logic [7:0]           tx_din,
  output logic                 tx_din_vld,
  input  logic                 tx_rdy,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int           GW      = $clog2(N);
  localparam bit           TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0]  TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [N-1:0] ACK_ONE = N'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  gnt_q, gnt_d;
  logic [7:0]     din_q, din_d;
  logic           last_q, last_d;
  logic           vld_q, vld_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [GW:0]    pick_s;
  logic [GW-1:0]  sel_s;
  logic [7:0]     sel_data_s;
  logic           sel_last_s;

  // Round-robin search starting at ptr; returns {found, index}. The loop runs
  // from the farthest candidate back to ptr so the nearest requester wins.
  function automatic logic [GW:0] rr_pick(input logic [N-1:0] vld,
                                          input logic [GW-1:0] ptr);
    logic [GW:0]   res;
    logic [GW-1:0] idx;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = GW'((int'(ptr) + i) % N);
      res = vld[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Index after idx, wrapping modulo N.
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    logic [GW-1:0] res;
    if (idx == GW'(N - 1)) begin
      res = '0;
    end else begin
      res = idx + GW'(1);
    end
    return res;
  endfunction

  assign pick_s = rr_pick(req_vld, ptr_q);
  // In IDLE the capture source is the arbitration winner, in NEXT it is the
  // current holder; the same mux serves both capture points.
  assign sel_s      = (state_q == IDLE) ? pick_s[GW-1:0] : gnt_q;
  assign sel_data_s = req_data[{sel_s, 3'b000} +: 8];
  assign sel_last_s = req_last[sel_s];

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    din_d   = din_q;
    last_d  = last_q;
    vld_d   = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
    cnt_d   = 16'd0;
    case (state_q)
      IDLE: begin
        // tx_rdy gates a new start, so a frame still running after reset
        // is never overlapped.
        if (tx_rdy && pick_s[GW]) begin
          gnt_d   = sel_s;
          din_d   = sel_data_s;
          last_d  = sel_last_s;
          vld_d   = 1'b1;
          ack_d   = ACK_ONE << sel_s;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        state_d = GUARD;
      end
      GUARD: begin
        // tx_rdy is still high here while the transmitter latches the byte.
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_rdy) begin
          if (last_q) begin
            ptr_d   = next_idx(gnt_q);
            state_d = IDLE;
          end else begin
            state_d = NEXT;
          end
        end else begin
          state_d = WAIT;
        end
      end
      NEXT: begin
        // A byte arriving on the terminal count cycle still wins.
        if (req_vld[gnt_q]) begin
          din_d   = sel_data_s;
          last_d  = sel_last_s;
          vld_d   = 1'b1;
          ack_d   = ACK_ONE << gnt_q;
          state_d = SEND;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          ptr_d   = next_idx(gnt_q);
          state_d = IDLE;
        end else begin
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          state_d = NEXT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      din_q   <= 8'h00;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      din_q   <= din_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ack     = ack_q;
  assign tx_din      = din_q;
  assign tx_din_vld  = vld_q;
  assign gnt_id      = gnt_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
